// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between a pipeline request port and a synchronous data memory.
// Ports: clk/rst (async active-high); req_* request handshake (we, addr, wdata, byte, lane, sign);
//        resp_* load response handshake; mem_* memory read address, read data (one-edge latency), write address/data/enable.
// Macro LSU_BYTE_EN enables byte loads (lane select, zero/sign fill) and read-modify-write byte stores; DATA_WIDTH must be >= 16 then.
module load_store_unit #(
  parameter int MEM_SIZE   = 512,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [$clog2(MEM_SIZE)-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]       req_wdata,
  input  logic                        req_byte,
  input  logic                        req_lane,
  input  logic                        req_sign,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_WIDTH-1:0]       resp_rdata,
  output logic [$clog2(MEM_SIZE)-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0]       mem_data_out,
  output logic [$clog2(MEM_SIZE)-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]       mem_data_in,
  output logic                        mem_write_enable
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_t;
  state_t r_state, w_next;
  logic w_accept, w_req_byte, w_rmw;
  logic [DATA_WIDTH-1:0] w_load, w_merged;
`ifdef LSU_BYTE_EN
  localparam logic [DATA_WIDTH-1:0] LANE_MASK = DATA_WIDTH'(8'hFF);
  logic r_we, r_byte, r_lane, r_sign;
  logic [7:0] r_wbyte, w_sel;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_we, r_byte, r_lane, r_sign, r_wbyte} <= '0;
    else if (w_accept) {r_we, r_byte, r_lane, r_sign, r_wbyte} <= {req_we, req_byte, req_lane, req_sign, req_wdata[7:0]};
  assign w_req_byte = req_byte;
  // only byte stores ever pass through RD_WAIT as a store
  assign w_rmw = r_we;
  assign w_sel = r_lane ? mem_data_out[15:8] : mem_data_out[7:0];
  assign w_load = r_byte ? {{(DATA_WIDTH-8){r_sign & w_sel[7]}}, w_sel} : mem_data_out;
  assign w_merged = r_lane ? ((mem_data_out & ~(LANE_MASK << 8)) | (DATA_WIDTH'(r_wbyte) << 8))
                           : ((mem_data_out & ~LANE_MASK) | DATA_WIDTH'(r_wbyte));
`else
  logic w_unused;
  assign w_unused = ^{req_byte, req_lane, req_sign};
  assign w_req_byte = 1'b0;
  assign w_rmw = 1'b0;
  assign w_load = mem_data_out;
  assign w_merged = mem_data_in;
`endif
  assign w_accept = (r_state == IDLE) && req_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = !req_valid ? IDLE : (req_we && !w_req_byte) ? WRITE : RD_ISSUE;
      RD_ISSUE: w_next = RD_WAIT;
      RD_WAIT:  w_next = w_rmw ? WRITE : RESP;
      WRITE:    w_next = IDLE;
      RESP:     w_next = resp_ready ? IDLE : RESP;
      default:  w_next = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_read_addr    <= '0;
      mem_write_addr   <= '0;
      mem_data_in      <= '0;
    end else begin
      req_ready        <= w_next == IDLE;
      resp_valid       <= w_next == RESP;
      mem_write_enable <= w_next == WRITE;
      if (w_accept) begin
        mem_read_addr  <= req_addr;
        mem_write_addr <= req_addr;
        mem_data_in    <= req_wdata;
      end
      if (r_state == RD_WAIT) begin
        if (w_rmw) mem_data_in <= w_merged;
        else resp_rdata <= w_load;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a transaction-level model and per-cycle output checking.
module tb_load_store_unit;
`ifdef LSU_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_lane = 1'b0, req_sign = 1'b0, resp_ready = 1'b1;
  logic [8:0] req_addr = '0;
  logic [15:0] req_wdata = '0, mem_data_out = '0;
  logic req_ready, resp_valid, mem_write_enable;
  logic [15:0] resp_rdata, mem_data_in;
  logic [8:0] mem_read_addr, mem_write_addr;
  logic [15:0] mem [512];
  logic [15:0] ref_mem [512];
  int cyc = 0, nchk = 0, nerr = 0;
  bit busy = 0, wait_resp = 0, wr_pend = 0, bt;
  int done_cyc, resp_cyc, wr_cyc;
  logic [8:0] wr_addr;
  logic [15:0] wr_data, exp_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte), .req_lane(req_lane),
    .req_sign(req_sign), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out), .mem_write_addr(mem_write_addr),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) mem[mem_write_addr] <= mem_data_in;
    mem_data_out <= mem[mem_read_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ld_val(input logic [15:0] w, input bit b, input bit l, input bit s);
    logic [7:0] x;
    x = l ? w[15:8] : w[7:0];
    return !b ? w : {{8{s & x[7]}}, x};
  endfunction

  function automatic logic [15:0] st_val(input logic [15:0] old, input logic [15:0] wd, input bit l);
    return l ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_we", mem_write_enable, 0);
      chk("rst_rd_addr", mem_read_addr, 0);
      chk("rst_wr_addr", mem_write_addr, 0);
      chk("rst_wr_data", mem_data_in, 0);
      busy = 0; wait_resp = 0; wr_pend = 0;
    end else begin
      if (busy && !wait_resp && cyc >= done_cyc) busy = 0;
      chk("req_ready", req_ready, !busy);
      chk("mem_we", mem_write_enable, wr_pend && cyc == wr_cyc);
      if (wr_pend && cyc == wr_cyc) begin
        chk("wr_addr", mem_write_addr, wr_addr);
        chk("wr_data", mem_data_in, wr_data);
        ref_mem[wr_addr] = wr_data;
        wr_pend = 0;
      end
      chk("resp_valid", resp_valid, wait_resp && cyc >= resp_cyc);
      if (wait_resp && cyc >= resp_cyc) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        if (resp_ready) begin wait_resp = 0; done_cyc = cyc + 1; end
      end
      if (req_valid && req_ready && !busy) begin
        bt = BYTE_EN && req_byte;
        busy = 1;
        if (!req_we) begin
          wait_resp = 1; resp_cyc = cyc + 3;
          exp_rdata = ld_val(ref_mem[req_addr], bt, req_lane, req_sign);
        end else begin
          wr_pend = 1; wr_addr = req_addr;
          wr_data = bt ? st_val(ref_mem[req_addr], req_wdata, req_lane) : req_wdata;
          wr_cyc = bt ? cyc + 3 : cyc + 1;
          done_cyc = bt ? cyc + 4 : cyc + 2;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [8:0] a, input logic [15:0] d, input bit b, input bit l, input bit s, input bit hold);
    int n;
    bit ok;
    req_we = we; req_addr = a; req_wdata = d; req_byte = b; req_lane = l; req_sign = s; req_valid = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 100) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; n++;
    end
    if (!ok) begin nchk++; nerr++; $display("FAIL accept_timeout: req_ready 0 for %0d cycles, required 1", n); end
    req_valid = hold;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 100);
    if (!req_ready) begin nchk++; nerr++; $display("FAIL idle_timeout: req_ready 0 after %0d cycles, required 1", n); end
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input string nm, input logic [15:0] exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk(nm, resp_rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin mem[i] = 16'(i * 37); ref_mem[i] = 16'(i * 37); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(1, 5, 16'hBEEF, 0, 0, 0, 0); wait_idle();
    chk("lit_mem5", mem[5], 16'hBEEF);
    issue(0, 5, 0, 0, 0, 0, 0);
    wait_rv("lit_load5", 16'hBEEF); wait_idle();
    issue(1, 9, 16'h8001, 0, 0, 0, 0); wait_idle();
    resp_ready = 1'b0;
    issue(0, 9, 0, 0, 0, 0, 0);
    wait_rv("lit_stall_first", 16'h8001);
    repeat (4) @(negedge clk);
    chk("lit_stall_rdata", resp_rdata, 16'h8001);
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_idle();
    issue(1, 7, 16'h1234, 0, 0, 0, 0); wait_idle();
    issue(1, 7, 16'h00AB, 1, 1, 0, 0); wait_idle();
    chk("lit_bstore_mem7", mem[7], BYTE_EN ? 16'hAB34 : 16'h00AB);
    issue(0, 7, 0, 1, 1, 1, 0); wait_rv("lit_bload_l1_sx", BYTE_EN ? 16'hFFAB : 16'h00AB); wait_idle();
    issue(0, 7, 0, 1, 1, 0, 0); wait_rv("lit_bload_l1_zx", 16'h00AB); wait_idle();
    issue(1, 8, 16'h7F80, 0, 0, 0, 0); wait_idle();
    issue(0, 8, 0, 1, 0, 1, 0); wait_rv("lit_bload_l0_sx", BYTE_EN ? 16'hFF80 : 16'h7F80); wait_idle();
    issue(0, 8, 0, 1, 1, 1, 0); wait_rv("lit_bload_l1_pos", BYTE_EN ? 16'h007F : 16'h7F80); wait_idle();
    issue(1, 8, 16'h3355, 1, 0, 0, 0); wait_idle();
    chk("lit_bstore_mem8", mem[8], BYTE_EN ? 16'h7F55 : 16'h3355);
    issue(0, 5, 0, 0, 0, 0, 1);
    issue(1, 6, 16'h4242, 0, 0, 0, 0); wait_idle();
    chk("lit_b2b_mem6", mem[6], 16'h4242);
    for (int i = 0; i < 6; i++) begin
      issue(1, 9'(100 + i), 16'(16'h1111 * i + 3), 0, 0, 0, 0); wait_idle();
    end
    for (int i = 0; i < 6; i++) begin
      issue(0, 9'(100 + i), 0, 0, 0, 0, 0); wait_idle();
    end
    issue(BYTE_EN, 7, 16'h00CD, 1, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lit_abort_mem7", mem[7], BYTE_EN ? 16'hAB34 : 16'h00AB);
    issue(0, 7, 0, 0, 0, 0, 0); wait_rv("lit_after_abort", BYTE_EN ? 16'hAB34 : 16'h00AB); wait_idle();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    nerr++;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 512, meaning the word depth of the attached data memory.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the memory word width; it SHALL be even.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: pipeline request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: request accepted on the edge where req_valid=1 and req_ready=1.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, $clog2(MEM_SIZE) bits: word address.
REQ-009 The block SHALL have port req_wdata, input, DATA_WIDTH bits: store data (byte store uses bits [7:0]).
REQ-010 The block SHALL have port req_byte, input, 1 bit: byte access.
REQ-011 The block SHALL have port req_lane, input, 1 bit: byte lane, 0 = [7:0], 1 = [15:8].
REQ-012 The block SHALL have port req_sign, input, 1 bit: sign-extend byte loads.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: load data available.
REQ-014 The block SHALL have port resp_ready, input, 1 bit: consumer takes the response.
REQ-015 The block SHALL have port resp_rdata, output, DATA_WIDTH bits: load result.
REQ-016 The block SHALL have port mem_read_addr, output, $clog2(MEM_SIZE) bits: to the data memory read address.
REQ-017 The block SHALL have port mem_data_out, input, DATA_WIDTH bits: memory read data, valid one edge after mem_read_addr.
REQ-018 The block SHALL have port mem_write_addr, output, $clog2(MEM_SIZE) bits: memory write address.
REQ-019 The block SHALL have port mem_data_in, output, DATA_WIDTH bits: memory write data.
REQ-020 The block SHALL have port mem_write_enable, output, 1 bit: memory write strobe.

Function
REQ-021 The block SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP, all outputs registered.
REQ-022 req_ready SHALL be 1 only in IDLE; one request SHALL be in flight at a time.
REQ-023 Request fields SHALL be latched on acceptance and held stable until return to IDLE.
REQ-024 Full-word store: IDLE->WRITE; in WRITE, mem_write_enable=1 for exactly one cycle with latched addr/data; WRITE->IDLE; no response generated.
REQ-025 Load: IDLE->RD_ISSUE (mem_read_addr=latched addr)->RD_WAIT (mem_data_out sampled)->RESP; resp_valid SHALL assert on the 3rd edge after acceptance.
REQ-026 In RESP, resp_valid and resp_rdata SHALL hold until resp_valid=1 and resp_ready=1, then RESP->IDLE.
REQ-027 A byte load SHALL return the selected lane in [7:0], with the upper bits zero-filled, or sign-filled if the latched req_sign=1.
REQ-028 A byte store SHALL be read-modify-write: RD_ISSUE->RD_WAIT (merge wdata[7:0] into the selected lane, keep the other lane)->WRITE->IDLE.
REQ-029 mem_write_enable SHALL be 0 in every state except WRITE.
REQ-030 req_valid=0 in IDLE SHALL leave state and all memory outputs unchanged.

Reset
REQ-031 On rst=1 the block SHALL asynchronously enter IDLE.
REQ-032 On rst=1 the outputs SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, mem_write_enable=0, all addresses and mem_data_in = 0.
REQ-033 Reset mid-operation SHALL abort the operation with no write issued; a pending response SHALL be dropped.

Configuration
REQ-034 The macro LSU_BYTE_EN SHALL control byte access support.
REQ-035 With LSU_BYTE_EN defined, req_byte, req_lane and req_sign SHALL be honoured as in REQ-027 and REQ-028.
REQ-036 Without LSU_BYTE_EN, req_byte, req_lane and req_sign SHALL be ignored, all accesses SHALL be full-word, and the read-modify-write path SHALL not be built.

Verification
REQ-037 Reset then store addr 5 = 0xBEEF, then load addr 5 -> one-cycle mem_write_enable with addr 5 and data 0xBEEF; resp_rdata=0xBEEF three edges after load acceptance.
REQ-038 With resp_ready held 0 for 4 cycles after a load -> resp_valid and resp_rdata stable and req_ready=0 throughout; back to IDLE one edge after resp_ready=1.
REQ-039 LSU_BYTE_EN: mem[7]=0x1234, byte store lane 1 data 0xAB -> mem[7]=0xAB34; byte load lane 1 sign=1 -> 0xFFAB; sign=0 -> 0x00AB.
REQ-040 No LSU_BYTE_EN: byte store lane 1 data 0x00AB to mem[7] -> mem[7]=0x00AB (full word).
REQ-041 rst asserted in RD_WAIT of a byte store -> no mem_write_enable pulse, memory unchanged, req_ready=1 immediately.
REQ-042 Back-to-back requests with req_valid held high -> only one accepted per IDLE visit; a store following a load returns the load response first.
